// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extension for the ARM-style datapath.
// Decodes the low 24 instruction bits according to ImmSrc into a 32-bit
// immediate, with a rotate carry-out and a flag for the reserved format.
// Results appear one clock after in_valid, qualified by out_valid.
module imm_extend_unit #(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [1:0]         ImmSrc,
  output logic [DATA_W-1:0]  ExtImm,
  output logic               out_valid,
  output logic               ShifterCarry,
  output logic               ImmIllegal
);

  typedef enum logic [1:0] {
    SRC_DP     = 2'b00,
    SRC_MEM    = 2'b01,
    SRC_BRANCH = 2'b10,
    SRC_RSVD   = 2'b11
  } imm_src_t;

  imm_src_t          src;
  logic [7:0]        imm8;
  logic [3:0]        rot;
  logic [DATA_W-1:0] dp_zext;
  logic [2*DATA_W-1:0] dp_doubled;
  logic [DATA_W-1:0] dp_rotated;

  logic [DATA_W-1:0] next_imm;
  logic              next_carry;
  logic              next_illegal;

  assign src  = imm_src_t'(ImmSrc);
  assign imm8 = Instruction[7:0];
  assign rot  = Instruction[11:8];

  // Rotate-right of the 8-bit immediate by twice the rotate field: shifting a
  // doubled copy right makes the wrapped bits land in the low word.
  always_comb begin
    dp_zext    = {{(DATA_W-8){1'b0}}, imm8};
    dp_doubled = {dp_zext, dp_zext} >> {rot, 1'b0};
    dp_rotated = dp_doubled[DATA_W-1:0];
  end

  // Format decode; the default arm matches the reserved encoding so no X escapes.
  always_comb begin
    next_imm     = '0;
    next_carry   = 1'b0;
    next_illegal = 1'b0;
    case (src)
      SRC_DP: begin
        next_imm   = dp_rotated;
        next_carry = (rot != 4'd0) ? dp_rotated[DATA_W-1] : 1'b0;
      end
      SRC_MEM: begin
        next_imm = {{(DATA_W-12){1'b0}}, Instruction[11:0]};
      end
      SRC_BRANCH: begin
        next_imm = {{(DATA_W-INSTR_W-2){Instruction[INSTR_W-1]}}, Instruction, 2'b00};
      end
      default: begin
        next_imm     = '0;
        next_illegal = 1'b1;
      end
    endcase
  end

  // Output register: capture on valid input, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ExtImm       <= '0;
      out_valid    <= 1'b0;
      ShifterCarry <= 1'b0;
      ImmIllegal   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ExtImm       <= next_imm;
        ShifterCarry <= next_carry;
        ImmIllegal   <= next_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Testbench for imm_extend_unit: scoreboard of expected results pushed when
// stimulus is driven, popped and compared one edge later.
module tb_imm_extend_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] Instruction;
  logic [1:0]  ImmSrc;
  logic [31:0] ExtImm;
  logic        out_valid;
  logic        ShifterCarry;
  logic        ImmIllegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] imm;
    logic        c;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  imm_extend_unit #(.DATA_W(32), .INSTR_W(24)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .Instruction(Instruction),
    .ImmSrc(ImmSrc),
    .ExtImm(ExtImm),
    .out_valid(out_valid),
    .ShifterCarry(ShifterCarry),
    .ImmIllegal(ImmIllegal)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, got, want);
    end
  endtask

  // Reference model written bit-by-bit, independent of the RTL's doubled shift.
  function automatic exp_t model(input logic [23:0] instr, input logic [1:0] src);
    exp_t e;
    logic [31:0] v;
    e.v = 1'b1; e.imm = '0; e.c = 1'b0; e.ill = 1'b0;
    case (src)
      2'b00: begin
        v = {24'd0, instr[7:0]};
        for (int i = 0; i < 2 * int'(instr[11:8]); i++) v = {v[0], v[31:1]};
        e.imm = v;
        e.c   = (instr[11:8] != 4'd0) ? v[31] : 1'b0;
      end
      2'b01: e.imm = {20'd0, instr[11:0]};
      2'b10: e.imm = {{6{instr[23]}}, instr, 2'b00};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue what must appear.
  task automatic applyStimulus(input logic v, input logic [23:0] instr, input logic [1:0] src);
    exp_t e;
    @(negedge clk);
    in_valid    = v;
    Instruction = instr;
    ImmSrc      = src;
    if (v) last = model(instr, src);
    e   = last;
    e.v = v;
    sb.push_back(e);
  endtask

  // Monitor: just after each rising edge, compare against the oldest queued entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      checkOutput("ExtImm", ExtImm, e.imm);
      checkOutput("ShifterCarry", {31'd0, ShifterCarry}, {31'd0, e.c});
      checkOutput("ImmIllegal", {31'd0, ImmIllegal}, {31'd0, e.ill});
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ExtImm"}, ExtImm, 32'd0);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_ShifterCarry"}, {31'd0, ShifterCarry}, 32'd0);
    checkOutput({tag, "_ImmIllegal"}, {31'd0, ImmIllegal}, 32'd0);
  endtask

  initial begin
    last = '{v: 1'b0, imm: 32'd0, c: 1'b0, ill: 1'b0};
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    Instruction = 24'h0001FF;
    ImmSrc      = 2'b00;
    #3;
    checkReset("reset_noclk");
    #30;
    checkReset("reset_clocked");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    $display("[TB] directed formats");
    applyStimulus(1'b1, 24'h0000C8, 2'b00);
    applyStimulus(1'b1, 24'h000F01, 2'b00);
    applyStimulus(1'b1, 24'h0001FF, 2'b00);
    applyStimulus(1'b1, 24'hFFF086, 2'b01);
    applyStimulus(1'b1, 24'hFFFFFE, 2'b10);
    applyStimulus(1'b1, 24'h000010, 2'b10);
    applyStimulus(1'b1, 24'h123456, 2'b11);
    applyStimulus(1'b0, 24'h0001FF, 2'b00);
    applyStimulus(1'b0, 24'h000000, 2'b01);
    applyStimulus(1'b1, 24'h800000, 2'b10);
    applyStimulus(1'b1, 24'h000AFF, 2'b00);

    $display("[TB] random back-to-back");
    for (int i = 0; i < 40; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 24'($urandom), 2'($urandom_range(0, 3)));

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 24'h0002FF, 2'b00);
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("reset_mid");
    sb.delete();
    last = '{v: 1'b0, imm: 32'd0, c: 1'b0, ill: 1'b0};
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    applyStimulus(1'b0, 24'h000000, 2'b00);
    applyStimulus(1'b1, 24'h000301, 2'b00);
    applyStimulus(1'b1, 24'h00ABCD, 2'b01);
    applyStimulus(1'b0, 24'hFFFFFF, 2'b11);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
